// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states
// and the helper that tells single-cycle ops from iterative ones.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_ADD   = 4'd2,
    OP_XOR   = 4'd3,
    OP_ANDN  = 4'd4,
    OP_ORN   = 4'd5,
    OP_SUB   = 4'd6,
    OP_SLTU  = 4'd7,
    OP_MULTU = 4'd8,
    OP_MULT  = 4'd9,
    OP_DIVU  = 4'd10,
    OP_DIV   = 4'd11,
    OP_MFHI  = 4'd12,
    OP_MFLO  = 4'd13,
    OP_SLT   = 4'd14,
    OP_ILL   = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_HOLD
  } state_e;

  function automatic logic is_iter(op_e op);
    return op inside {OP_MULTU, OP_MULT, OP_DIVU, OP_DIV};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on magnitudes,
// one bit per cycle, with sign fix-up applied on the final cycle.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, q, mag_b;
  logic             md, neg_q, neg_r;

  logic [WIDTH-1:0]   a_mag, b_mag, addend;
  logic [WIDTH-1:0]   acc_n, q_n;
  logic [WIDTH:0]     sum, sh, diff;
  logic [2*WIDTH-1:0] prod, prod_s;

  always_comb begin
    a_mag  = (sgn & a[WIDTH-1]) ? -a : a;
    b_mag  = (sgn & b[WIDTH-1]) ? -b : b;
    addend = q[0] ? mag_b : '0;
    sum    = {1'b0, acc} + {1'b0, addend};
    sh     = {acc, q[WIDTH-1]};
    diff   = sh - {1'b0, mag_b};
    if (md) begin
      acc_n = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
      q_n   = {q[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      acc_n = sum[WIDTH:1];
      q_n   = {sum[0], q[WIDTH-1:1]};
    end
    prod   = {acc_n, q_n};
    prod_s = neg_q ? -prod : prod;
    done   = busy & (cnt == CW'(WIDTH-1));
    if (md) begin
      hi = neg_r ? -acc_n : acc_n;
      lo = neg_q ? -q_n : q_n;
    end else begin
      hi = prod_s[2*WIDTH-1:WIDTH];
      lo = prod_s[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      q     <= '0;
      mag_b <= '0;
      md    <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      acc   <= '0;
      q     <= a_mag;
      mag_b <= b_mag;
      md    <= mode;
      neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= sgn & a[WIDTH-1];
    end else if (busy) begin
      acc <= acc_n;
      q   <= q_n;
      cnt <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU top: handshake FSM, single-cycle datapath,
// HI/LO architectural registers and registered result outputs.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state, state_n;
  op_e              opc;
  logic             accept, dz, start;
  logic             sgn, mode, done;
  logic [WIDTH-1:0] sc_res, m_hi, m_lo;
  logic             sc_err;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_HOLD);

  muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sgn   (sgn),
    .mode  (mode),
    .a     (in1),
    .b     (in2),
    .done  (done),
    .hi    (m_hi),
    .lo    (m_lo)
  );

  always_comb begin
    opc    = op_e'(op);
    accept = in_valid & in_ready;
    dz     = (opc == OP_DIVU || opc == OP_DIV) && (in2 == '0);
    start  = accept & is_iter(opc) & ~dz;
    sgn    = (opc == OP_MULT) || (opc == OP_DIV);
    mode   = (opc == OP_DIVU) || (opc == OP_DIV);
    sc_err = 1'b0;
    case (opc)
      OP_AND:  sc_res = in1 & in2;
      OP_OR:   sc_res = in1 | in2;
      OP_ADD:  sc_res = in1 + in2;
      OP_XOR:  sc_res = in1 ^ in2;
      OP_ANDN: sc_res = in1 & ~in2;
      OP_ORN:  sc_res = in1 | ~in2;
      OP_SUB:  sc_res = in1 - in2;
      OP_SLTU: sc_res = WIDTH'(in1 < in2);
      OP_SLT:  sc_res = WIDTH'($signed(in1) < $signed(in2));
      OP_MFHI: sc_res = hi;
      OP_MFLO: sc_res = lo;
      OP_ILL: begin
        sc_res = '0;
        sc_err = 1'b1;
      end
      default: begin
        // only reached on the single-cycle path for divide by zero
        sc_res = '1;
        sc_err = dz;
      end
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (accept) state_n = start ? S_CALC : S_HOLD;
      S_CALC: if (done) state_n = S_HOLD;
      S_HOLD: if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      result <= '0;
      zero   <= 1'b1;
      err    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_n;
      if (accept && !start) begin
        result <= sc_res;
        zero   <= (sc_res == '0);
        err    <= sc_err;
      end else if (state == S_CALC && done) begin
        hi     <= m_hi;
        lo     <= m_lo;
        result <= m_lo;
        zero   <= (m_lo == '0);
        err    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (>=4, even).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have port op  input  4  operation code (see REQ-012).
REQ-007 SHALL have port in1, in2  input  WIDTH  operands.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port result  output  WIDTH; zero  output  1 (result == 0); err  output  1 (illegal op or divide by zero).
REQ-011 SHALL have port hi, lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-012 op: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 in1&~in2, 5 in1|~in2, 6 SUB, 7 SLTU (unsigned), 8 MULTU, 9 MULT, 10 DIVU, 11 DIV, 12 MFHI, 13 MFLO, 14 SLT (signed), 15 illegal.
REQ-013 FSM states IDLE, CALC, HOLD; in_ready = (state == IDLE); out_valid = (state == HOLD).
REQ-014 Accept = in_valid & in_ready; operands and op captured at accept; later input changes ignored.
REQ-015 Ops 0-7, 12-15: IDLE -> HOLD on accept; result, zero, err registered same edge (latency 1).
REQ-016 Ops 8-11 with nonzero divisor: IDLE -> CALC; iterative engine runs exactly WIDTH cycles; on last cycle HI/LO update and state -> HOLD with result = new LO.
REQ-017 HOLD -> IDLE when out_ready; result/zero/err hold stable while out_valid & !out_ready.
REQ-018 ADD/SUB wrap modulo 2^WIDTH; no overflow flag; SLT/SLTU result 1 or 0, zero-extended.
REQ-019 MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned respectively.
REQ-020 DIV/DIVU: lo = quotient, hi = remainder; signed quotient truncates toward zero, remainder takes sign of dividend.
REQ-021 DIV with in1 = -2^(WIDTH-1), in2 = -1: lo = -2^(WIDTH-1), hi = 0, err = 0.
REQ-022 Divide by zero (ops 10/11, in2 = 0): IDLE -> HOLD in one cycle, HI/LO unchanged, result = all ones, err = 1.
REQ-023 Op 15: result = 0, zero = 1, err = 1, HI/LO unchanged.
REQ-024 MFHI/MFLO return HI/LO as updated by any previously completed operation, including one completing the cycle before accept.
REQ-025 HI/LO change only at completion of ops 8-11; never during CALC.

Reset
REQ-026 Asynchronous reset forces state IDLE, result 0, zero 1, err 0, hi 0, lo 0, iteration counter 0.
REQ-027 Reset in CALC or HOLD aborts the operation; no partial HI/LO update; in_ready = 1 on the first clock edge after reset deasserts.

Structure
REQ-028 Package alu_pkg SHALL hold the op enum (4-bit), FSM state enum and the op-class helper (single-cycle vs iterative).
REQ-029 Iterative shift-add multiply and restoring divide SHALL be one sub-module, muldiv_iter (start, signed, mode, operands in; done, hi, lo out), with sign correction inside it.
REQ-030 Top level SHALL hold the FSM, single-cycle datapath, HI/LO registers and output registers.

Verification (WIDTH = 32)
REQ-031 ADD 0x7FFFFFFF + 1 -> result 0x80000000, zero 0, out_valid the cycle after accept; SUB 5 - 5 -> result 0, zero 1.
REQ-032 MULT 0xFFFFFFFE x 3 -> after 32 CALC cycles hi 0xFFFFFFFF, lo 0xFFFFFFFA, result 0xFFFFFFFA; then MFHI -> 0xFFFFFFFF.
REQ-033 DIV -7 / 2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF; DIVU 7 / 0 -> result 0xFFFFFFFF, err 1, hi/lo unchanged, out_valid after 1 cycle.
REQ-034 out_ready held 0 for 5 cycles in HOLD -> result stable, in_ready 0, new in_valid ignored; out_ready 1 -> IDLE next cycle.
REQ-035 Reset asserted at CALC cycle 10 of MULTU -> hi = lo = 0, out_valid 0; subsequent SLTU 1 < 2 -> result 1.
